// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer for the split even/odd byte banks (CPU vs loader).
// Define ARB_CPU_PRIORITY_EN for fixed CPU priority on ties; default is round-robin.
module data_memory_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_size,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_wdata,
  output logic              ld_ack,
  output logic [15:0]       ld_rdata,
  output logic              even_we,
  output logic              odd_we,
  output logic [ADDR_W-2:0] even_addr,
  output logic [ADDR_W-2:0] odd_addr,
  output logic [7:0]        even_wdata,
  output logic [7:0]        odd_wdata,
  input  logic [7:0]        even_rdata,
  input  logic [7:0]        odd_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;     // 0 = cpu, 1 = loader
  logic              last_q, last_d;
  logic              rd_q, rd_d;
  logic              size_q, size_d;
  logic              a0_q, a0_d;
  logic              ewe_q, ewe_d, owe_q, owe_d;
  logic [ADDR_W-2:0] eaddr_q, eaddr_d, oaddr_q, oaddr_d;
  logic [7:0]        ewd_q, ewd_d, owd_q, owd_d;
  logic [15:0]       crd_q, crd_d, lrd_q, lrd_d;

  logic              sel_ld;
  logic              w_we, w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       w_wdata;
  logic [ADDR_W-2:0] h, h_inc;
  logic [15:0]       rd_asm;

  always_comb begin
    if (cpu_req && ld_req) begin
`ifdef ARB_CPU_PRIORITY_EN
      sel_ld = 1'b0;
`else
      sel_ld = ~last_q;
`endif
    end else begin
      sel_ld = ld_req;
    end
  end

  assign w_we    = sel_ld ? ld_we    : cpu_we;
  assign w_size  = sel_ld ? ld_size  : cpu_size;
  assign w_addr  = sel_ld ? ld_addr  : cpu_addr;
  assign w_wdata = sel_ld ? ld_wdata : cpu_wdata;

  // Unaligned halfword high byte lands in the next even word; wraps at the top.
  assign h     = w_addr[ADDR_W-1:1];
  assign h_inc = h + {{(ADDR_W-2){1'b0}}, 1'b1};

  always_comb begin
    if (size_q) rd_asm = a0_q ? {even_rdata, odd_rdata} : {odd_rdata, even_rdata};
    else        rd_asm = {8'h00, a0_q ? odd_rdata : even_rdata};
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rd_d    = rd_q;
    size_d  = size_q;
    a0_d    = a0_q;
    ewe_d   = 1'b0;
    owe_d   = 1'b0;
    eaddr_d = eaddr_q;
    oaddr_d = oaddr_q;
    ewd_d   = ewd_q;
    owd_d   = owd_q;
    crd_d   = crd_q;
    lrd_d   = lrd_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          gnt_d   = sel_ld;
          last_d  = sel_ld;
          rd_d    = ~w_we;
          size_d  = w_size;
          a0_d    = w_addr[0];
          eaddr_d = (w_size && w_addr[0]) ? h_inc : h;
          oaddr_d = h;
          ewd_d   = w_addr[0] ? w_wdata[15:8] : w_wdata[7:0];
          owd_d   = w_addr[0] ? w_wdata[7:0]  : w_wdata[15:8];
          ewe_d   = w_we && (w_size || !w_addr[0]);
          owe_d   = w_we && (w_size ||  w_addr[0]);
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = rd_q ? WAIT : DONE;
      WAIT: begin
        if (gnt_q) lrd_d = rd_asm;
        else       crd_d = rd_asm;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      size_q  <= 1'b0;
      a0_q    <= 1'b0;
      ewe_q   <= 1'b0;
      owe_q   <= 1'b0;
      eaddr_q <= '0;
      oaddr_q <= '0;
      ewd_q   <= '0;
      owd_q   <= '0;
      crd_q   <= '0;
      lrd_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      size_q  <= size_d;
      a0_q    <= a0_d;
      ewe_q   <= ewe_d;
      owe_q   <= owe_d;
      eaddr_q <= eaddr_d;
      oaddr_q <= oaddr_d;
      ewd_q   <= ewd_d;
      owd_q   <= owd_d;
      crd_q   <= crd_d;
      lrd_q   <= lrd_d;
    end
  end

  assign cpu_ack    = (state_q == DONE) && !gnt_q;
  assign ld_ack     = (state_q == DONE) &&  gnt_q;
  assign cpu_stall  = cpu_req && !cpu_ack;
  assign cpu_rdata  = crd_q;
  assign ld_rdata   = lrd_q;
  assign even_we    = ewe_q;
  assign odd_we     = owe_q;
  assign even_addr  = eaddr_q;
  assign odd_addr   = oaddr_q;
  assign even_wdata = ewd_q;
  assign odd_wdata  = owd_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: synchronous bank models plus a flat byte-addressed
// reference memory; directed scenarios followed by randomized sequential traffic.
module tb_data_memory_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_size, ld_req, ld_we, ld_size;
  logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic        cpu_ack, ld_ack, cpu_stall;
  logic [15:0] cpu_rdata, ld_rdata;
  logic        even_we, odd_we;
  logic [14:0] even_addr, odd_addr;
  logic [7:0]  even_wdata, odd_wdata, even_rdata, odd_rdata;

  logic [7:0]  even_mem [0:32767];
  logic [7:0]  odd_mem  [0:32767];
  logic [7:0]  ref_mem  [0:65535];
  int          vectors = 0;
  int          miscompares = 0;
  int          we_cycles = 0;
  bit          last_ld;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_size(ld_size), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .even_we(even_we), .odd_we(odd_we), .even_addr(even_addr), .odd_addr(odd_addr),
    .even_wdata(even_wdata), .odd_wdata(odd_wdata),
    .even_rdata(even_rdata), .odd_rdata(odd_rdata)
  );

  // Synchronous banks, read-before-write, one cycle latency.
  always @(posedge clk) begin
    even_rdata <= even_mem[even_addr];
    odd_rdata  <= odd_mem[odd_addr];
    if (even_we) even_mem[even_addr] = even_wdata;
    if (odd_we)  odd_mem[odd_addr]   = odd_wdata;
  end

  always @(negedge clk) if (even_we || odd_we) we_cycles++;

  // Reference model: a flat byte memory, halfword = bytes a and a+1 (16-bit wrap).
  function automatic logic [15:0] ref_read(input logic [15:0] a, input bit sz);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return sz ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  function automatic void ref_write(input logic [15:0] a, input bit sz, input logic [15:0] wd);
    logic [15:0] a1;
    a1 = a + 16'd1;
    ref_mem[a] = wd[7:0];
    if (sz) ref_mem[a1] = wd[15:8];
  endfunction

  function automatic logic [7:0] bank_byte(input logic [15:0] b);
    return b[0] ? odd_mem[b[15:1]] : even_mem[b[15:1]];
  endfunction

  function automatic void preload(input logic [15:0] b, input logic [7:0] v);
    ref_mem[b] = v;
    if (b[0]) odd_mem[b[15:1]] = v;
    else      even_mem[b[15:1]] = v;
  endfunction

  task automatic txn(input bit who, input bit we, input bit sz, input logic [15:0] a,
                     input logic [15:0] wd, output int lat, output logic [15:0] rd,
                     output longint t);
    logic ack;
    if (who) begin ld_we = we; ld_size = sz; ld_addr = a; ld_wdata = wd; ld_req = 1'b1; end
    else begin cpu_we = we; cpu_size = sz; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1; end
    lat = 0; rd = '0; t = 0;
    forever begin
      @(posedge clk); lat++;
      @(negedge clk);
      ack = who ? ld_ack : cpu_ack;
      if (ack) begin rd = who ? ld_rdata : cpu_rdata; t = $time; break; end
      if (lat >= 60) begin
        vectors++; miscompares++;
        $display("FAIL ack_timeout requester=%0d: no ack, required ack within 60 cycles", who);
        break;
      end
    end
    @(posedge clk); #1;
    if (who) ld_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if ({cpu_ack, ld_ack, even_we, odd_we, cpu_stall} !== 5'b0) begin miscompares++;
      $display("FAIL reset_ctl got %b want 00000", {cpu_ack, ld_ack, even_we, odd_we, cpu_stall}); end
    vectors++; if ({cpu_rdata, ld_rdata} !== 32'h0) begin miscompares++;
      $display("FAIL reset_rdata got %h want 0", {cpu_rdata, ld_rdata}); end
    vectors++; if ({even_addr, odd_addr, even_wdata, odd_wdata} !== 46'h0) begin miscompares++;
      $display("FAIL reset_bank got %h want 0", {even_addr, odd_addr, even_wdata, odd_wdata}); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_cpu_half_write;
    cpu_we = 1'b1; cpu_size = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
    @(posedge clk); @(negedge clk);
    vectors++; if ({even_we, odd_we, even_addr, odd_addr} !== {2'b11, 15'h0008, 15'h0008}) begin
      miscompares++; $display("FAIL hw_issue_ctl got we=%b%b ea=%h oa=%h want we=11 ea=0008 oa=0008",
      even_we, odd_we, even_addr, odd_addr); end
    vectors++; if ({even_wdata, odd_wdata} !== 16'hEFBE) begin miscompares++;
      $display("FAIL hw_issue_data got %h want efbe", {even_wdata, odd_wdata}); end
    vectors++; if ({cpu_ack, cpu_stall} !== 2'b01) begin miscompares++;
      $display("FAIL hw_issue_ack got ack/stall=%b want 01", {cpu_ack, cpu_stall}); end
    @(posedge clk); @(negedge clk);
    vectors++; if ({cpu_ack, cpu_stall, even_we, odd_we} !== 4'b1000) begin miscompares++;
      $display("FAIL hw_done got ack/stall/we=%b want 1000", {cpu_ack, cpu_stall, even_we, odd_we}); end
    @(posedge clk); #1 cpu_req = 1'b0;
    @(negedge clk);
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++;
      $display("FAIL hw_ack_one_cycle got %b want 0", cpu_ack); end
    ref_write(16'h0010, 1'b1, 16'hBEEF);
    vectors++; if ({even_mem[8], odd_mem[8]} !== 16'hEFBE) begin miscompares++;
      $display("FAIL hw_banks got %h want efbe", {even_mem[8], odd_mem[8]}); end
    @(posedge clk); #1;
  endtask

  task automatic test_unaligned_read;
    int lat; logic [15:0] rd; longint t;
    preload(16'h0011, 8'h34); preload(16'h0012, 8'h12);
    txn(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, lat, rd, t);
    vectors++; if (rd !== 16'h1234) begin miscompares++;
      $display("FAIL unaligned_rdata got %h want 1234", rd); end
    vectors++; if (lat !== 3) begin miscompares++;
      $display("FAIL unaligned_latency got %0d want 3", lat); end
  endtask

  task automatic test_wrap;
    int lat; logic [15:0] rd; longint t;
    txn(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hA55A, lat, rd, t);
    ref_write(16'hFFFF, 1'b1, 16'hA55A);
    vectors++; if ({odd_mem[15'h7FFF], even_mem[0]} !== 16'h5AA5) begin miscompares++;
      $display("FAIL wrap_banks got %h want 5aa5", {odd_mem[15'h7FFF], even_mem[0]}); end
    vectors++; if (lat !== 2) begin miscompares++;
      $display("FAIL wrap_latency got %0d want 2", lat); end
  endtask

  task automatic test_byte_read;
    int lat, w0; logic [15:0] rd; longint t;
    preload(16'h0003, 8'h80);
    w0 = we_cycles;
    txn(1'b0, 1'b0, 1'b0, 16'h0003, 16'h5AA5, lat, rd, t);
    vectors++; if (rd !== 16'h0080) begin miscompares++;
      $display("FAIL byte_rdata got %h want 0080", rd); end
    vectors++; if (we_cycles !== w0) begin miscompares++;
      $display("FAIL byte_no_we got %0d write cycles want 0", we_cycles - w0); end
    vectors++; if (lat !== 3) begin miscompares++;
      $display("FAIL byte_latency got %0d want 3", lat); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] rd, exp; longint t;
    cpu_we = 1'b0; cpu_size = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 16'h5AA5; cpu_req = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0; cpu_req = 1'b0;
    #1;
    vectors++; if ({cpu_ack, ld_ack, even_we, odd_we} !== 4'b0) begin miscompares++;
      $display("FAIL rstmid_ctl got %b want 0000", {cpu_ack, ld_ack, even_we, odd_we}); end
    vectors++; if ({cpu_rdata, ld_rdata} !== 32'h0) begin miscompares++;
      $display("FAIL rstmid_rdata got %h want 0", {cpu_rdata, ld_rdata}); end
    vectors++; if ({even_addr, odd_addr, even_wdata, odd_wdata} !== 46'h0) begin miscompares++;
      $display("FAIL rstmid_bank got %h want 0", {even_addr, odd_addr, even_wdata, odd_wdata}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (cpu_ack !== 1'b0) begin miscompares++;
        $display("FAIL rstmid_no_ack cycle %0d got %b want 0", i, cpu_ack); end
    end
    @(posedge clk); #1 reset = 1'b1;
    exp = ref_read(16'h0010, 1'b1);
    txn(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, lat, rd, t);
    vectors++; if (rd !== exp) begin miscompares++;
      $display("FAIL rstmid_fresh_rdata got %h want %h", rd, exp); end
    vectors++; if (lat !== 3) begin miscompares++;
      $display("FAIL rstmid_fresh_latency got %0d want 3", lat); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] rd, exp; longint t1, t2;
    txn(1'b0, 1'b1, 1'b1, 16'h0400, 16'h1357, lat, rd, t1);
    txn(1'b0, 1'b1, 1'b0, 16'h0405, 16'h00C3, lat, rd, t2);
    ref_write(16'h0400, 1'b1, 16'h1357); ref_write(16'h0405, 1'b0, 16'h00C3);
    vectors++; if (t2 - t1 !== 64'd30) begin miscompares++;
      $display("FAIL b2b_write_period got %0d want 30", t2 - t1); end
    txn(1'b1, 1'b0, 1'b1, 16'h0400, 16'h0000, lat, rd, t1);
    exp = ref_read(16'h0405, 1'b0);
    txn(1'b1, 1'b0, 1'b0, 16'h0405, 16'h0000, lat, rd, t2);
    vectors++; if (t2 - t1 !== 64'd40) begin miscompares++;
      $display("FAIL b2b_read_period got %0d want 40", t2 - t1); end
    vectors++; if (rd !== exp) begin miscompares++;
      $display("FAIL b2b_read_data got %h want %h", rd, exp); end
  endtask

  task automatic test_tie;
    int lc, ll, lat; logic [15:0] rc, rl, rd, ca, la, lw, exp; longint tc, tl, t;
    bit exp_ld, who;
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    last_ld = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r > 0 && $urandom_range(0, 1) == 1) begin
        who = 1'($urandom_range(0, 1));
        txn(who, 1'b0, 1'b0, 16'h3000, 16'h0000, lat, rd, t);
        last_ld = who;
      end
      ca = 16'h1000 | 16'($urandom_range(0, 255));
      la = 16'h2000 | 16'($urandom_range(0, 255));
      lw = 16'($urandom);
      exp = ref_read(ca, 1'b1);
`ifdef ARB_CPU_PRIORITY_EN
      exp_ld = 1'b0;
`else
      exp_ld = !last_ld;
`endif
      fork
        txn(1'b0, 1'b0, 1'b1, ca, 16'h0000, lc, rc, tc);
        txn(1'b1, 1'b1, 1'b1, la, lw, ll, rl, tl);
      join
      ref_write(la, 1'b1, lw);
      last_ld = !exp_ld;
      vectors++; if ((tl < tc) !== exp_ld) begin miscompares++;
        $display("FAIL tie_winner round %0d got ld_first=%0d want %0d", r, tl < tc, exp_ld); end
      vectors++; if ((exp_ld ? {ll, lc} : {lc, ll}) !== (exp_ld ? {32'd2, 32'd6} : {32'd3, 32'd6})) begin
        miscompares++; $display("FAIL tie_latency round %0d got cpu=%0d ld=%0d", r, lc, ll); end
      vectors++; if (rc !== exp) begin miscompares++;
        $display("FAIL tie_rdata round %0d got %h want %h", r, rc, exp); end
      vectors++; if ({bank_byte(la + 16'd1), bank_byte(la)} !== lw) begin miscompares++;
        $display("FAIL tie_write round %0d got %h want %h", r, {bank_byte(la + 16'd1), bank_byte(la)}, lw); end
    end
  endtask

  task automatic test_random;
    int lat, w0; logic [15:0] a, wd, rd, exp, a1; longint t; bit who, we, sz;
    for (int i = 0; i < 60; i++) begin
      who = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); sz = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom_range(0, 63));
      wd = 16'($urandom);
      exp = ref_read(a, sz);
      w0 = we_cycles;
      txn(who, we, sz, a, wd, lat, rd, t);
      vectors++; if (lat !== (we ? 2 : 3)) begin miscompares++;
        $display("FAIL rnd_latency #%0d got %0d want %0d", i, lat, we ? 2 : 3); end
      vectors++; if (we_cycles - w0 !== (we ? 1 : 0)) begin miscompares++;
        $display("FAIL rnd_we_cycles #%0d got %0d want %0d", i, we_cycles - w0, we ? 1 : 0); end
      if (we) begin
        ref_write(a, sz, wd);
        a1 = a + 16'd1;
        vectors++; if ({bank_byte(a1), bank_byte(a)} !== {ref_mem[a1], ref_mem[a]}) begin miscompares++;
          $display("FAIL rnd_write #%0d addr %h got %h want %h", i, a,
                   {bank_byte(a1), bank_byte(a)}, {ref_mem[a1], ref_mem[a]}); end
      end else begin
        vectors++; if (rd !== exp) begin miscompares++;
          $display("FAIL rnd_read #%0d addr %h size %0d got %h want %h", i, a, sz, rd, exp); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_size = 1'b0; ld_addr = '0; ld_wdata = '0;
    for (int b = 0; b < 65536; b++) preload(16'(b), 8'($urandom));
    test_reset();
    test_cpu_half_write();
    test_unaligned_read();
    test_wrap();
    test_byte_read();
    test_reset_mid();
    test_back_to_back();
    test_tie();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-requester arbiter and sequencer for the split even/odd 8-bit data memory banks. It shares the banks between the processor memory stage (`cpu_*`) and a bulk image loader/DMA port (`ld_*`). For each granted transaction it splits a byte or halfword access into per-bank byte operations, including unaligned halfwords that straddle both banks. It sits between the memory stage and the two `data_memory` instances, on the processor-side port only; the VGA read port is not touched.

## Interface
- `ADDR_W`, 16: byte address width; bank address width is `ADDR_W-1`.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_size`  in  1  0 = byte, 1 = halfword.
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  16  write data; low byte goes to `cpu_addr`.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  16  read data, zero-extended for byte reads; valid while `cpu_ack` is high.
- `cpu_stall`  out  1  `cpu_req && !cpu_ack`; drives the pipeline stall.
- `ld_req`, `ld_we`, `ld_size`, `ld_addr`, `ld_wdata`, `ld_ack`, `ld_rdata`: same definitions as the `cpu_*` ports, for the loader.
- `even_we`, `odd_we`  out  1  bank write enables.
- `even_addr`, `odd_addr`  out  ADDR_W-1  bank addresses.
- `even_wdata`, `odd_wdata`  out  8  bank write data.
- `even_rdata`, `odd_rdata`  in  8  bank read data; synchronous, 1-cycle latency.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If either `req` is high, select a winner and latch its we/size/addr/wdata. Record the winner in `last_grant`, then go to ISSUE.
  - If no `req` is high, stay in IDLE.
- **ISSUE**
  - Drive the bank ports from the latched command.
  - Write: go to DONE.
  - Read: go to WAIT.
- **WAIT**: capture the assembled bank read data into the winner's `rdata` register, then go to DONE.
- **DONE**: assert the winner's `ack` for exactly one cycle, then go to IDLE.
- **Arbitration**
  - A single `req` wins outright.
  - If both are high, round-robin: grant the requester that is not `last_grant`.
- **Lane mapping** (address `a`, `h = a >> 1`)
  - Byte access: touches only bank `a[0]` (0 = even) at address `h`.
  - Halfword, `a[0]=0`: even bank at `h` carries the low byte; odd bank at `h` carries the high byte.
  - Halfword, `a[0]=1`: odd bank at `h` carries the low byte; even bank at `h+1` carries the high byte. The `h+1` increment is truncated to `ADDR_W-1` bits, so `a = 0xFFFF` wraps the even address to 0.
  - Read: `rdata = {high byte, low byte}`; for byte reads `rdata[15:8] = 0`. Sign extension is not performed here.
  - Outside ISSUE, `even_we` and `odd_we` are 0. Bank addresses hold their last value.
- **Requester behaviour**
  - Deasserting `req` mid-transaction has no effect; the transaction completes and `ack` still pulses.
  - A requester must drop `req` on the edge that ends its `ack` cycle. If `req` is still high in the following IDLE, it is treated as a new request.

## Timing
- **Write**: `req` sampled at edge E0, bank write at E1, `ack` high during the cycle E1–E2. Total 2 cycles.
- **Read**: `req` sampled at E0, bank read issued in ISSUE (E0–E1), data registered at E2, `ack` and `rdata` valid during E2–E3. Total 3 cycles.
- **Throughput**:
  - The loser of a simultaneous request is granted at the IDLE immediately after the winner's DONE.
  - A single requester, back-to-back: one idle cycle between transactions.
- **Reset** (asynchronous, any state):
  - state = IDLE
  - `cpu_ack` = `ld_ack` = 0
  - `cpu_rdata` = `ld_rdata` = 0
  - `even_we` = `odd_we` = 0
  - bank addresses and write data = 0
  - `last_grant` = loader, so the CPU wins the first tie
  - An in-flight write that has not yet reached ISSUE is dropped. No `ack` is issued for an aborted transaction.

## Configuration
- `ARB_CPU_PRIORITY_EN`
  - Defined: fixed priority. `cpu_req` always wins a tie; `last_grant` is still updated but ignored.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- **CPU halfword write**: `cpu_addr=0x0010`, `cpu_wdata=0xBEEF`, `cpu_size=1` -> `even_addr=0x0008`/0xEF and `odd_addr=0x0008`/0xBE written in the same cycle; `cpu_ack` pulses 2 cycles after the request.
- **Unaligned halfword read**: `ld_addr=0x0011`, odd[0x0008]=0x34, even[0x0009]=0x12 -> `ld_rdata=0x1234`, `ld_ack` 3 cycles after the request.
- **Wrap-around**: halfword write at `0xFFFF`, data `0xA55A` -> odd[0x7FFF]=0x5A, even[0x0000]=0xA5.
- **Simultaneous requests out of reset**: CPU read and loader write -> CPU acked first, loader acked in the next transaction. Repeated ties alternate grants (skip the alternation check when `ARB_CPU_PRIORITY_EN` is defined).
- **Byte read**: `cpu_addr=0x0003`, odd[0x0001]=0x80 -> `cpu_rdata=0x0080`, `even_we` and `odd_we` both stay 0 throughout.
- **Reset mid-operation**: assert `reset` low in WAIT -> outputs return to their reset values immediately. After release, a fresh CPU request completes normally in 3 cycles.
